// File: rtl/wd_responder_if.sv
// Byte-access bus between the frame processor and the watchdog register block.
// Handshake: wd_valid qualifies wd_addr/wd_read/wd_wdata for one cycle; wd_ready (with wd_rdata) answers exactly one cycle later; no backpressure.
interface wd_responder_if;
    logic        wd_sof;
    logic        wd_eof;
    logic        wd_valid;
    logic [15:0] wd_addr;
    logic        wd_read;
    logic [7:0]  wd_wdata;
    logic        wd_ready;
    logic [7:0]  wd_rdata;

    modport master (
        output wd_sof, wd_eof, wd_valid, wd_addr, wd_read, wd_wdata,
        input  wd_ready, wd_rdata
    );

    modport slave (
        input  wd_sof, wd_eof, wd_valid, wd_addr, wd_read, wd_wdata,
        output wd_ready, wd_rdata
    );
endinterface

// File: rtl/wd_responder.sv
// Watchdog register block: frame-staged byte writes, shared tick divider,
// SM and PDI watchdog timers with expiry pulses and saturating expiry counters.
module wd_responder #(
    parameter logic [15:0] DIV_RST      = 16'h09C2,
    parameter logic [15:0] PDI_TIME_RST = 16'h03E8,
    parameter logic [15:0] SM_TIME_RST  = 16'h03E8
) (
    input  logic           clk,
    input  logic           rst,
    wd_responder_if.slave  wd,
    input  logic           sm_wd_trigger,
    input  logic           pdi_wd_trigger,
    output logic           sm_wd_status,
    output logic           sm_wd_expired,
    output logic           pdi_wd_expired
);

    logic [15:0]      div_q, div_d, pdi_time_q, pdi_time_d, sm_time_q, sm_time_d;
    logic [5:0][7:0]  stg_data_q, stg_data_d, mrg_data;
    logic [5:0]       stg_vld_q, stg_vld_d, mrg_vld, wr_sel;
    logic             stg_clr_sm_q, stg_clr_sm_d, stg_clr_pdi_q, stg_clr_pdi_d;
    logic             mrg_clr_sm, mrg_clr_pdi, wr_clr_sm, wr_clr_pdi;
    logic             div_c, pdi_c, sm_c, clr_sm, clr_pdi;
    logic [16:0]      dcnt_q, dcnt_d;
    logic             tick;
    logic [15:0]      sm_tmr_q, sm_tmr_d, pdi_tmr_q, pdi_tmr_d;
    logic [7:0]       sm_cnt_q, sm_cnt_d, pdi_cnt_q, pdi_cnt_d;
    logic             sm_load, pdi_load, sm_fire, pdi_fire;
    logic             status_q, status_d, sm_exp_q, pdi_exp_q;
    logic             ready_q, ready_d;
    logic [7:0]       rdata_q, rdata_d, rd_byte;

    // Write decode: slots 0..5 are divider L/H, PDI time L/H, SM time L/H.
    always_comb begin
        wr_sel     = '0;
        wr_clr_sm  = 1'b0;
        wr_clr_pdi = 1'b0;
        if (wd.wd_valid && !wd.wd_read) begin
            case (wd.wd_addr)
                16'h0400: wr_sel[0] = 1'b1;
                16'h0401: wr_sel[1] = 1'b1;
                16'h0410: wr_sel[2] = 1'b1;
                16'h0411: wr_sel[3] = 1'b1;
                16'h0420: wr_sel[4] = 1'b1;
                16'h0421: wr_sel[5] = 1'b1;
                16'h0442: wr_clr_sm = 1'b1;
                16'h0443: wr_clr_pdi = 1'b1;
                default: ;
            endcase
        end
    end

    // sof drops older staged bytes before this cycle's write is merged in.
    always_comb begin
        mrg_vld     = wd.wd_sof ? 6'd0 : stg_vld_q;
        mrg_data    = stg_data_q;
        mrg_clr_sm  = (!wd.wd_sof && stg_clr_sm_q) || wr_clr_sm;
        mrg_clr_pdi = (!wd.wd_sof && stg_clr_pdi_q) || wr_clr_pdi;
        for (int i = 0; i < 6; i++) begin
            if (wr_sel[i]) begin
                mrg_vld[i]  = 1'b1;
                mrg_data[i] = wd.wd_wdata;
            end
        end
    end

    always_comb begin
        div_c   = wd.wd_eof && (|mrg_vld[1:0]);
        pdi_c   = wd.wd_eof && (|mrg_vld[3:2]);
        sm_c    = wd.wd_eof && (|mrg_vld[5:4]);
        clr_sm  = wd.wd_eof && mrg_clr_sm;
        clr_pdi = wd.wd_eof && mrg_clr_pdi;

        div_d[7:0]       = (wd.wd_eof && mrg_vld[0]) ? mrg_data[0] : div_q[7:0];
        div_d[15:8]      = (wd.wd_eof && mrg_vld[1]) ? mrg_data[1] : div_q[15:8];
        pdi_time_d[7:0]  = (wd.wd_eof && mrg_vld[2]) ? mrg_data[2] : pdi_time_q[7:0];
        pdi_time_d[15:8] = (wd.wd_eof && mrg_vld[3]) ? mrg_data[3] : pdi_time_q[15:8];
        sm_time_d[7:0]   = (wd.wd_eof && mrg_vld[4]) ? mrg_data[4] : sm_time_q[7:0];
        sm_time_d[15:8]  = (wd.wd_eof && mrg_vld[5]) ? mrg_data[5] : sm_time_q[15:8];

        stg_vld_d     = wd.wd_eof ? 6'd0 : mrg_vld;
        stg_data_d    = mrg_data;
        stg_clr_sm_d  = wd.wd_eof ? 1'b0 : mrg_clr_sm;
        stg_clr_pdi_d = wd.wd_eof ? 1'b0 : mrg_clr_pdi;
    end

    always_comb begin
        rd_byte = 8'd0;
        case (wd.wd_addr)
            16'h0400: rd_byte = div_q[7:0];
            16'h0401: rd_byte = div_q[15:8];
            16'h0410: rd_byte = pdi_time_q[7:0];
            16'h0411: rd_byte = pdi_time_q[15:8];
            16'h0420: rd_byte = sm_time_q[7:0];
            16'h0421: rd_byte = sm_time_q[15:8];
            16'h0440: rd_byte = {7'd0, status_q};
            16'h0442: rd_byte = sm_cnt_q;
            16'h0443: rd_byte = pdi_cnt_q;
            default:  rd_byte = 8'd0;
        endcase
        ready_d = wd.wd_valid;
        rdata_d = (wd.wd_valid && wd.wd_read) ? rd_byte : 8'd0;
    end

    // Reload (trigger, own time commit, divider commit) wins over a same-cycle expiry.
    always_comb begin
        tick     = (dcnt_q == ({1'b0, div_q} + 17'd1));
        dcnt_d   = (div_c || tick) ? 17'd0 : dcnt_q + 17'd1;

        sm_load  = sm_wd_trigger || sm_c || div_c;
        pdi_load = pdi_wd_trigger || pdi_c || div_c;
        sm_fire  = !sm_load && tick && (sm_tmr_q == 16'd1);
        pdi_fire = !pdi_load && tick && (pdi_tmr_q == 16'd1);

        sm_tmr_d = sm_tmr_q;
        if (sm_load)                         sm_tmr_d = sm_time_d;
        else if (tick && sm_tmr_q != 16'd0)  sm_tmr_d = sm_tmr_q - 16'd1;

        pdi_tmr_d = pdi_tmr_q;
        if (pdi_load)                        pdi_tmr_d = pdi_time_d;
        else if (tick && pdi_tmr_q != 16'd0) pdi_tmr_d = pdi_tmr_q - 16'd1;

        sm_cnt_d = sm_cnt_q;
        if (clr_sm)                               sm_cnt_d = {7'd0, sm_fire};
        else if (sm_fire && sm_cnt_q != 8'hFF)    sm_cnt_d = sm_cnt_q + 8'd1;

        pdi_cnt_d = pdi_cnt_q;
        if (clr_pdi)                              pdi_cnt_d = {7'd0, pdi_fire};
        else if (pdi_fire && pdi_cnt_q != 8'hFF)  pdi_cnt_d = pdi_cnt_q + 8'd1;

        status_d = status_q;
        if (sm_wd_trigger || sm_c || sm_time_d == 16'd0) status_d = 1'b1;
        else if (sm_fire)                                status_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= DIV_RST;
            pdi_time_q    <= PDI_TIME_RST;
            sm_time_q     <= SM_TIME_RST;
            stg_data_q    <= '0;
            stg_vld_q     <= '0;
            stg_clr_sm_q  <= 1'b0;
            stg_clr_pdi_q <= 1'b0;
            dcnt_q        <= '0;
            sm_tmr_q      <= SM_TIME_RST;
            pdi_tmr_q     <= PDI_TIME_RST;
            sm_cnt_q      <= '0;
            pdi_cnt_q     <= '0;
            status_q      <= 1'b1;
            sm_exp_q      <= 1'b0;
            pdi_exp_q     <= 1'b0;
            ready_q       <= 1'b0;
            rdata_q       <= '0;
        end else begin
            div_q         <= div_d;
            pdi_time_q    <= pdi_time_d;
            sm_time_q     <= sm_time_d;
            stg_data_q    <= stg_data_d;
            stg_vld_q     <= stg_vld_d;
            stg_clr_sm_q  <= stg_clr_sm_d;
            stg_clr_pdi_q <= stg_clr_pdi_d;
            dcnt_q        <= dcnt_d;
            sm_tmr_q      <= sm_tmr_d;
            pdi_tmr_q     <= pdi_tmr_d;
            sm_cnt_q      <= sm_cnt_d;
            pdi_cnt_q     <= pdi_cnt_d;
            status_q      <= status_d;
            sm_exp_q      <= sm_fire;
            pdi_exp_q     <= pdi_fire;
            ready_q       <= ready_d;
            rdata_q       <= rdata_d;
        end
    end

    assign wd.wd_ready    = ready_q;
    assign wd.wd_rdata    = rdata_q;
    assign sm_wd_status   = status_q;
    assign sm_wd_expired  = sm_exp_q;
    assign pdi_wd_expired = pdi_exp_q;

endmodule

// File: tb/tb_wd_responder.sv
// Bench for wd_responder: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the register map and watchdogs.
module tb_wd_responder;
    localparam logic [15:0] DIV_RST = 16'h09C2;
    localparam logic [15:0] PDI_RST = 16'h03E8;
    localparam logic [15:0] SM_RST  = 16'h03E8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sm_wd_trigger = 1'b0;
    logic pdi_wd_trigger = 1'b0;
    logic sm_wd_status, sm_wd_expired, pdi_wd_expired;

    wd_responder_if wd ();

    wd_responder #(.DIV_RST(DIV_RST), .PDI_TIME_RST(PDI_RST), .SM_TIME_RST(SM_RST)) dut (
        .clk            (clk),
        .rst            (rst),
        .wd             (wd),
        .sm_wd_trigger  (sm_wd_trigger),
        .pdi_wd_trigger (pdi_wd_trigger),
        .sm_wd_status   (sm_wd_status),
        .sm_wd_expired  (sm_wd_expired),
        .pdi_wd_expired (pdi_wd_expired)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_div, m_pdi_time, m_sm_time, m_cnt, m_sm_tmr, m_pdi_tmr, m_sm_ec, m_pdi_ec, m_rdata;
    bit m_status, m_ready, m_sm_exp, m_pdi_exp;
    byte unsigned stage [int];
    int n_assert = 0;
    int n_fail = 0;

    function automatic int model_read(input int a);
        case (a)
            'h400: return m_div & 'hFF;
            'h401: return (m_div >> 8) & 'hFF;
            'h410: return m_pdi_time & 'hFF;
            'h411: return (m_pdi_time >> 8) & 'hFF;
            'h420: return m_sm_time & 'hFF;
            'h421: return (m_sm_time >> 8) & 'hFF;
            'h440: return int'(m_status);
            'h442: return m_sm_ec;
            'h443: return m_pdi_ec;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        int a, rd_n;
        bit tick, div_c, pdi_c, sm_c, clr_sm, clr_pdi, sm_f, pdi_f;
        if (rst) begin
            m_div = DIV_RST; m_pdi_time = PDI_RST; m_sm_time = SM_RST;
            m_sm_tmr = SM_RST; m_pdi_tmr = PDI_RST; m_cnt = 0;
            m_sm_ec = 0; m_pdi_ec = 0; m_status = 1'b1;
            m_ready = 1'b0; m_rdata = 0; m_sm_exp = 1'b0; m_pdi_exp = 1'b0;
            stage.delete();
            return;
        end
        a = int'(wd.wd_addr);
        rd_n = (wd.wd_valid && wd.wd_read) ? model_read(a) : 0;
        tick = (m_cnt == m_div + 1);
        div_c = 0; pdi_c = 0; sm_c = 0; clr_sm = 0; clr_pdi = 0;
        if (wd.wd_sof) stage.delete();
        if (wd.wd_valid && !wd.wd_read) stage[a] = wd.wd_wdata;
        if (wd.wd_eof) begin
            foreach (stage[k]) begin
                case (k)
                    'h400: begin m_div = (m_div & 'hFF00) | int'(stage[k]); div_c = 1; end
                    'h401: begin m_div = (m_div & 'h00FF) | (int'(stage[k]) << 8); div_c = 1; end
                    'h410: begin m_pdi_time = (m_pdi_time & 'hFF00) | int'(stage[k]); pdi_c = 1; end
                    'h411: begin m_pdi_time = (m_pdi_time & 'h00FF) | (int'(stage[k]) << 8); pdi_c = 1; end
                    'h420: begin m_sm_time = (m_sm_time & 'hFF00) | int'(stage[k]); sm_c = 1; end
                    'h421: begin m_sm_time = (m_sm_time & 'h00FF) | (int'(stage[k]) << 8); sm_c = 1; end
                    'h442: clr_sm = 1;
                    'h443: clr_pdi = 1;
                    default: ;
                endcase
            end
            stage.delete();
        end
        m_cnt = (div_c || tick) ? 0 : m_cnt + 1;
        sm_f = 0;
        pdi_f = 0;
        if (sm_wd_trigger || sm_c || div_c) m_sm_tmr = m_sm_time;
        else if (tick && m_sm_tmr != 0) begin m_sm_tmr -= 1; sm_f = (m_sm_tmr == 0); end
        if (pdi_wd_trigger || pdi_c || div_c) m_pdi_tmr = m_pdi_time;
        else if (tick && m_pdi_tmr != 0) begin m_pdi_tmr -= 1; pdi_f = (m_pdi_tmr == 0); end
        if (clr_sm) m_sm_ec = 0;
        if (clr_pdi) m_pdi_ec = 0;
        if (sm_f && m_sm_ec < 255) m_sm_ec += 1;
        if (pdi_f && m_pdi_ec < 255) m_pdi_ec += 1;
        if (sm_f) m_status = 1'b0;
        if (sm_wd_trigger || sm_c || m_sm_time == 0) m_status = 1'b1;
        m_sm_exp = sm_f;
        m_pdi_exp = pdi_f;
        m_ready = wd.wd_valid;
        m_rdata = rd_n;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("ready", wd.wd_ready, m_ready);
        chk("rdata", wd.wd_rdata, m_rdata[7:0]);
        chk("sm_status", sm_wd_status, m_status);
        chk("sm_expired", sm_wd_expired, m_sm_exp);
        chk("pdi_expired", pdi_wd_expired, m_pdi_exp);
    endtask

    task automatic idle_inputs();
        wd.wd_sof = 1'b0; wd.wd_eof = 1'b0; wd.wd_valid = 1'b0;
        wd.wd_addr = 16'h0; wd.wd_read = 1'b0; wd.wd_wdata = 8'h0;
        sm_wd_trigger = 1'b0; pdi_wd_trigger = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic access(input bit r, input logic [15:0] a, input logic [7:0] d,
                          input bit sof, input bit eof);
        wd.wd_valid = 1'b1; wd.wd_read = r; wd.wd_addr = a; wd.wd_wdata = d;
        wd.wd_sof = sof; wd.wd_eof = eof;
        cycle();
        idle_inputs();
    endtask

    task automatic frame(input bit sof, input bit eof);
        wd.wd_sof = sof; wd.wd_eof = eof;
        cycle();
        idle_inputs();
    endtask

    task automatic read_chk(input logic [15:0] a, input logic [7:0] exp, input string tag);
        access(1'b1, a, 8'h0, 1'b0, 1'b0);
        chk(tag, wd.wd_rdata, exp);
        chk({tag, "_ready"}, wd.wd_ready, 1'b1);
    endtask

    task automatic pulse_sm();
        sm_wd_trigger = 1'b1;
        cycle();
        idle_inputs();
    endtask

    task automatic pulse_pdi();
        pdi_wd_trigger = 1'b1;
        cycle();
        idle_inputs();
    endtask

    initial begin
        logic [15:0] addr_tab [9];
        bit bad;
        addr_tab = '{16'h0400, 16'h0401, 16'h0410, 16'h0411, 16'h0420,
                     16'h0421, 16'h0440, 16'h0442, 16'h0443};
        idle_inputs();
        rst = 1'b1;
        idle(3);
        chk("rst_ready", wd.wd_ready, 1'b0);
        chk("rst_rdata", wd.wd_rdata, 8'h00);
        chk("rst_status", sm_wd_status, 1'b1);
        chk("rst_sm_exp", sm_wd_expired, 1'b0);
        rst = 1'b0;

        read_chk(16'h0400, 8'hC2, "div_l_rst");
        read_chk(16'h0401, 8'h09, "div_h_rst");
        idle(1);

        access(1'b0, 16'h0410, 8'h34, 1'b0, 1'b0);
        read_chk(16'h0410, 8'hE8, "pdi_l_staged");
        frame(1'b0, 1'b1);
        read_chk(16'h0410, 8'h34, "pdi_l_commit");

        // divider=0, SM time=3, committed together; trigger right after
        access(1'b0, 16'h0400, 8'h00, 1'b0, 1'b0);
        access(1'b0, 16'h0401, 8'h00, 1'b0, 1'b0);
        access(1'b0, 16'h0421, 8'h00, 1'b0, 1'b0);
        access(1'b0, 16'h0420, 8'h03, 1'b0, 1'b1);
        pulse_sm();
        for (int k = 2; k <= 7; k++) begin
            cycle();
            chk("sm_exp_at_6", sm_wd_expired, (k == 6));
        end
        chk("sm_status_expired", sm_wd_status, 1'b0);
        read_chk(16'h0442, 8'h01, "sm_cnt_one");
        read_chk(16'h0440, 8'h00, "status_reg_zero");

        // Retrigger in the expiry cycle
        access(1'b0, 16'h0400, 8'h00, 1'b0, 1'b1);
        pulse_sm();
        idle(4);
        pulse_sm();
        chk("retrig_no_pulse", sm_wd_expired, 1'b0);
        chk("retrig_status", sm_wd_status, 1'b1);
        for (int k = 2; k <= 8; k++) begin
            cycle();
            chk("reload_exp_at_7", sm_wd_expired, (k == 7));
        end
        read_chk(16'h0442, 8'h02, "sm_cnt_two");

        access(1'b0, 16'h0442, 8'hAA, 1'b0, 1'b0);
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b1);
        read_chk(16'h0442, 8'h02, "clr_discarded");
        access(1'b0, 16'h0442, 8'h00, 1'b0, 1'b0);
        frame(1'b0, 1'b1);
        read_chk(16'h0442, 8'h00, "clr_committed");

        access(1'b0, 16'h0410, 8'h55, 1'b0, 1'b0);
        access(1'b0, 16'h0411, 8'h12, 1'b1, 1'b1);
        read_chk(16'h0410, 8'h34, "sofeof_l");
        read_chk(16'h0411, 8'h12, "sofeof_h");

        // SM time 0 committed while the timer runs
        pulse_sm();
        idle(2);
        access(1'b0, 16'h0420, 8'h00, 1'b0, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            if (sm_wd_expired !== 1'b0 || sm_wd_status !== 1'b1) bad = 1'b1;
        end
        chk("sm_disabled_quiet", bad, 1'b0);
        read_chk(16'h0440, 8'h01, "status_reg_one");

        // PDI counter saturation, then clear coinciding with an expiry
        access(1'b0, 16'h0410, 8'h01, 1'b0, 1'b0);
        access(1'b0, 16'h0411, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 260; i++) begin
            pulse_pdi();
            idle(2);
        end
        read_chk(16'h0443, 8'hFF, "pdi_cnt_sat");
        access(1'b0, 16'h0400, 8'h00, 1'b0, 1'b1);
        idle(1);
        access(1'b0, 16'h0443, 8'h00, 1'b0, 1'b1);
        chk("pdi_exp_coincide", pdi_wd_expired, 1'b1);
        read_chk(16'h0443, 8'h01, "clr_inc_coincide");

        for (int i = 0; i < 1500; i++) begin
            int pick;
            pick = $urandom_range(0, 9);
            wd.wd_valid = ($urandom_range(0, 2) == 0);
            wd.wd_read = 1'($urandom_range(0, 1));
            wd.wd_addr = (pick == 9) ? 16'(16'h0400 + $urandom_range(0, 'h4F)) : addr_tab[pick];
            wd.wd_wdata = (wd.wd_addr[0] && wd.wd_addr <= 16'h0421) ? 8'h00 : 8'($urandom_range(0, 5));
            wd.wd_sof = ($urandom_range(0, 15) == 0);
            wd.wd_eof = ($urandom_range(0, 7) == 0);
            sm_wd_trigger = ($urandom_range(0, 40) == 0);
            pdi_wd_trigger = ($urandom_range(0, 40) == 0);
            cycle();
        end
        idle_inputs();
        idle(2);

        // Reset in the middle of a frame drops the staged byte
        access(1'b0, 16'h0410, 8'h77, 1'b0, 1'b0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        frame(1'b0, 1'b1);
        read_chk(16'h0410, 8'hE8, "rst_drops_stage");
        read_chk(16'h0400, 8'hC2, "rst_div_restored");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
